multi_decode_stage: RTL and testbench

MULTI_DECODE_STAGE -- requirements
Module: multi_decode_stage

---
 rtl/multi_decode_stage_pkg.sv | 71 +++++++
 rtl/multi_decode_stage_if.sv | 35 +++
 rtl/multi_decode_stage_lane_decoder.sv | 94 +++++++++
 rtl/multi_decode_stage.sv | 114 +++++++++++
 tb/tb_multi_decode_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/multi_decode_stage_pkg.sv
// Shared decode definitions: instruction widths, opcode/funct codes, control-bit layout,
// FSM state type and the per-lane decoded record used by multi_decode_stage.
package multi_decode_stage_pkg;

    localparam int IWIDTH       = 32;
    localparam int AWIDTH       = 5;
    localparam int IMM_WIDTH    = 16;
    localparam int JUMP_WIDTH   = 26;
    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;

    localparam int MDS_CTRL_WIDTH = 9;

    // Control vector layout, MSB first: {ce,jr,jal,reg_wr,branch,alu_src,reg_dst,memtoreg,memwrite}
    localparam int CTRL_MEMWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REG_DST  = 2;
    localparam int CTRL_ALU_SRC  = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_REG_WR   = 5;
    localparam int CTRL_JAL      = 6;
    localparam int CTRL_JR       = 7;
    localparam int CTRL_CE       = 8;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_JR = 6'h08;

    localparam logic [AWIDTH-1:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        MDS_IDLE  = 2'd0,
        MDS_HOLD  = 2'd1,
        MDS_SPLIT = 2'd2
    } mds_state_e;

    typedef struct packed {
        logic [MDS_CTRL_WIDTH-1:0] ctrl;
        logic [OPCODE_WIDTH-1:0]   opcode;
        logic [FUNCT_WIDTH-1:0]    funct;
        logic [AWIDTH-1:0]         rs;
        logic [AWIDTH-1:0]         rt;
        logic [AWIDTH-1:0]         rd;
        logic [IMM_WIDTH-1:0]      imm;
        logic [JUMP_WIDTH-1:0]     jal_addr;
        logic [AWIDTH-1:0]         dest;
        logic                      use_rs;
        logic                      use_rt;
    } mds_dec_t;

    // Register written by a lane; 0 means "writes nothing" since $0 is hardwired.
    function automatic logic [AWIDTH-1:0] mds_dest(input logic [MDS_CTRL_WIDTH-1:0] ctrl,
                                                   input logic [AWIDTH-1:0] rt,
                                                   input logic [AWIDTH-1:0] rd);
        logic [AWIDTH-1:0] d;
        d = ctrl[CTRL_REG_DST] ? rd : rt;
        return ctrl[CTRL_REG_WR] ? d : '0;
    endfunction

endpackage

// File: rtl/multi_decode_stage_if.sv
// Fetch-side / issue-side signal bundle of multi_decode_stage; master = fetch+issue
// environment, slave = the decode stage.
interface multi_decode_stage_if
    import multi_decode_stage_pkg::*;
#(
    parameter int LANES = 2
);
    logic                             md_i_valid;
    logic                             md_o_ready;
    logic [LANES-1:0]                 md_i_lane_vld;
    logic [LANES*IWIDTH-1:0]          md_i_instr;
    logic                             md_i_flush;
    logic                             md_i_out_ready;
    logic [LANES-1:0]                 md_o_valid;
    logic [LANES*MDS_CTRL_WIDTH-1:0]  md_o_ctrl;
    logic [LANES*OPCODE_WIDTH-1:0]    md_o_opcode;
    logic [LANES*FUNCT_WIDTH-1:0]     md_o_funct;
    logic [LANES*AWIDTH-1:0]          md_o_rs;
    logic [LANES*AWIDTH-1:0]          md_o_rt;
    logic [LANES*AWIDTH-1:0]          md_o_rd;
    logic [LANES*IMM_WIDTH-1:0]       md_o_imm;
    logic [LANES*JUMP_WIDTH-1:0]      md_o_jal_addr;

    modport master (
        output md_i_valid, md_i_lane_vld, md_i_instr, md_i_flush, md_i_out_ready,
        input  md_o_ready, md_o_valid, md_o_ctrl, md_o_opcode, md_o_funct,
               md_o_rs, md_o_rt, md_o_rd, md_o_imm, md_o_jal_addr
    );

    modport slave (
        input  md_i_valid, md_i_lane_vld, md_i_instr, md_i_flush, md_i_out_ready,
        output md_o_ready, md_o_valid, md_o_ctrl, md_o_opcode, md_o_funct,
               md_o_rs, md_o_rt, md_o_rd, md_o_imm, md_o_jal_addr
    );
endinterface

// File: rtl/multi_decode_stage_lane_decoder.sv
// Combinational single-instruction decoder: raw fields, control vector, destination
// register and which source registers the instruction actually reads.
module lane_decoder
    import multi_decode_stage_pkg::*;
(
    input  logic [IWIDTH-1:0] instr_i,
    output mds_dec_t          dec_o
);

    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [FUNCT_WIDTH-1:0]    funct;
    logic                      known;
    logic [MDS_CTRL_WIDTH-1:0] ctrl;
    logic [AWIDTH-1:0]         rs;
    logic [AWIDTH-1:0]         rd;
    logic [JUMP_WIDTH-1:0]     jal_addr;
    logic                      use_rs;
    logic                      use_rt;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    always_comb begin
        known    = 1'b1;
        ctrl     = '0;
        rs       = instr_i[25:21];
        rd       = instr_i[15:11];
        jal_addr = '0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FUNCT_JR) begin
                    ctrl[CTRL_JR] = 1'b1;
                    rs            = REG_RA;
                    use_rs        = 1'b1;
                end else begin
                    ctrl[CTRL_REG_WR]  = 1'b1;
                    ctrl[CTRL_REG_DST] = 1'b1;
                    use_rs             = 1'b1;
                    use_rt             = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: begin
                ctrl[CTRL_ALU_SRC] = 1'b1;
                ctrl[CTRL_REG_WR]  = 1'b1;
                use_rs             = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl[CTRL_BRANCH] = 1'b1;
                use_rs            = 1'b1;
                use_rt            = 1'b1;
            end
            OP_LW: begin
                ctrl[CTRL_MEMTOREG] = 1'b1;
                ctrl[CTRL_REG_WR]   = 1'b1;
                ctrl[CTRL_ALU_SRC]  = 1'b1;
                use_rs              = 1'b1;
            end
            OP_SW: begin
                ctrl[CTRL_MEMWRITE] = 1'b1;
                ctrl[CTRL_ALU_SRC]  = 1'b1;
                use_rs              = 1'b1;
                use_rt              = 1'b1;
            end
            OP_JAL: begin
                ctrl[CTRL_JAL]     = 1'b1;
                ctrl[CTRL_REG_WR]  = 1'b1;
                ctrl[CTRL_REG_DST] = 1'b1;
                rd                 = REG_RA;
                jal_addr           = instr_i[25:0];
            end
            default: known = 1'b0;
        endcase

        dec_o = '0;
        // Unrecognised opcodes leave the whole record zero, including ce.
        if (known) begin
            ctrl[CTRL_CE]  = 1'b1;
            dec_o.ctrl     = ctrl;
            dec_o.opcode   = opcode;
            dec_o.funct    = funct;
            dec_o.rs       = rs;
            dec_o.rt       = instr_i[20:16];
            dec_o.rd       = rd;
            dec_o.imm      = instr_i[15:0];
            dec_o.jal_addr = jal_addr;
            dec_o.dest     = mds_dest(ctrl, instr_i[20:16], rd);
            dec_o.use_rs   = use_rs;
            dec_o.use_rt   = use_rt;
        end
    end

endmodule

// File: rtl/multi_decode_stage.sv
// Multi-lane decode stage with registered outputs and a 1-deep output hold.
// Define MDS_SPLIT_EN to split bundles at intra-bundle RAW hazards (SPLIT state).
module multi_decode_stage
    import multi_decode_stage_pkg::*;
#(
    parameter int LANES = 2
)(
    input  logic                 md_i_clk,
    input  logic                 md_i_rst,
    multi_decode_stage_if.slave  md_bus
);

    mds_state_e              state_q, state_d;
    logic [LANES-1:0]        vld_q, vld_d;
    logic [LANES-1:0]        pend_q, pend_d;
    mds_dec_t [LANES-1:0]    dec_q, dec_d;
    mds_dec_t [LANES-1:0]    dec_w;
    logic [LANES-1:0]        iss;
    logic                    accept;

    // Pending lanes below the first one that reads a register written by an earlier
    // pending lane may issue together; if there is no such lane, all pending lanes go.
    function automatic logic [LANES-1:0] issue_mask(input logic [LANES-1:0] pend,
                                                    input mds_dec_t [LANES-1:0] d);
        logic [LANES-1:0] m;
        logic             found;
        m     = pend;
        found = 1'b0;
        for (int k = 1; k < LANES; k++) begin
            if (!found && pend[k]) begin
                for (int j = 0; j < k; j++) begin
                    if (pend[j] && (d[j].dest != '0) &&
                        ((d[k].use_rs && (d[k].rs == d[j].dest)) ||
                         (d[k].use_rt && (d[k].rt == d[j].dest))))
                        found = 1'b1;
                end
                if (found)
                    m = pend & ((LANES'(1) << k) - LANES'(1));
            end
        end
        return m;
    endfunction

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_decoder u_dec (
            .instr_i (md_bus.md_i_instr[k*IWIDTH +: IWIDTH]),
            .dec_o   (dec_w[k])
        );
        assign md_bus.md_o_ctrl[k*MDS_CTRL_WIDTH +: MDS_CTRL_WIDTH] = dec_q[k].ctrl;
        assign md_bus.md_o_opcode[k*OPCODE_WIDTH +: OPCODE_WIDTH]   = dec_q[k].opcode;
        assign md_bus.md_o_funct[k*FUNCT_WIDTH +: FUNCT_WIDTH]      = dec_q[k].funct;
        assign md_bus.md_o_rs[k*AWIDTH +: AWIDTH]                   = dec_q[k].rs;
        assign md_bus.md_o_rt[k*AWIDTH +: AWIDTH]                   = dec_q[k].rt;
        assign md_bus.md_o_rd[k*AWIDTH +: AWIDTH]                   = dec_q[k].rd;
        assign md_bus.md_o_imm[k*IMM_WIDTH +: IMM_WIDTH]            = dec_q[k].imm;
        assign md_bus.md_o_jal_addr[k*JUMP_WIDTH +: JUMP_WIDTH]     = dec_q[k].jal_addr;
    end

    assign md_bus.md_o_valid = vld_q;
    assign md_bus.md_o_ready = (state_q != MDS_SPLIT) &&
                               (!(|vld_q) || md_bus.md_i_out_ready);
    assign accept            = md_bus.md_i_valid && md_bus.md_o_ready;

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        pend_d  = pend_q;
        dec_d   = dec_q;
        iss     = '0;
        if (md_bus.md_i_flush) begin
            vld_d   = '0;
            pend_d  = '0;
            state_d = MDS_IDLE;
        end else if (state_q == MDS_SPLIT) begin
            if (md_bus.md_i_out_ready) begin
                iss     = issue_mask(pend_q, dec_q);
                vld_d   = iss;
                pend_d  = pend_q & ~iss;
                state_d = (pend_d != '0) ? MDS_SPLIT : MDS_HOLD;
            end
        end else if (accept) begin
            dec_d = dec_w;
`ifdef MDS_SPLIT_EN
            iss   = issue_mask(md_bus.md_i_lane_vld, dec_w);
`else
            iss   = md_bus.md_i_lane_vld;
`endif
            vld_d  = iss;
            pend_d = md_bus.md_i_lane_vld & ~iss;
            if (iss == '0)
                state_d = MDS_IDLE;
            else
                state_d = (pend_d != '0) ? MDS_SPLIT : MDS_HOLD;
        end else if ((|vld_q) && md_bus.md_i_out_ready) begin
            vld_d   = '0;
            state_d = MDS_IDLE;
        end
    end

    always_ff @(posedge md_i_clk or posedge md_i_rst) begin
        if (md_i_rst) begin
            state_q <= MDS_IDLE;
            vld_q   <= '0;
            pend_q  <= '0;
            dec_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            pend_q  <= pend_d;
            dec_q   <= dec_d;
        end
    end

endmodule

// File: tb/tb_multi_decode_stage.sv
// Directed bench for multi_decode_stage (LANES=2): decode vector table plus
// hand-written stall, split, flush and mid-operation reset sequences.
module tb_multi_decode_stage;
    localparam int LANES = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_decode_stage_if #(.LANES(LANES)) bus ();
    multi_decode_stage #(.LANES(LANES)) dut (
        .md_i_clk (clk),
        .md_i_rst (rst),
        .md_bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] i0, i1;
        logic [1:0]  lv, evld;
        logic        chk0, chk1;
        logic [8:0]  c0, c1;
        logic [11:0] of0, of1;
        logic [30:0] f0, f1;
        logic [25:0] j0, j1;
    } vec_t;

    vec_t vt[7];

    function automatic logic [11:0] opf(input int op, input int fn);
        return {6'(op), 6'(fn)};
    endfunction

    function automatic logic [30:0] fld(input int rs, input int rt, input int rd, input int imm);
        return {5'(rs), 5'(rt), 5'(rd), 16'(imm)};
    endfunction

    function automatic vec_t mk(input logic [31:0] i0, input logic [31:0] i1,
                                input logic [1:0] lv, input logic [1:0] evld,
                                input logic chk0, input logic chk1,
                                input logic [8:0] c0, input logic [8:0] c1,
                                input logic [11:0] of0, input logic [11:0] of1,
                                input logic [30:0] f0, input logic [30:0] f1,
                                input logic [25:0] j0, input logic [25:0] j1);
        vec_t v;
        v.i0 = i0; v.i1 = i1; v.lv = lv; v.evld = evld; v.chk0 = chk0; v.chk1 = chk1;
        v.c0 = c0; v.c1 = c1; v.of0 = of0; v.of1 = of1; v.f0 = f0; v.f1 = f1;
        v.j0 = j0; v.j1 = j1;
        return v;
    endfunction

    function automatic logic [30:0] act_f(input int l);
        return {bus.md_o_rs[l*5 +: 5], bus.md_o_rt[l*5 +: 5],
                bus.md_o_rd[l*5 +: 5], bus.md_o_imm[l*16 +: 16]};
    endfunction

    function automatic logic [11:0] act_of(input int l);
        return {bus.md_o_opcode[l*6 +: 6], bus.md_o_funct[l*6 +: 6]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] lv);
        bus.md_i_valid    = 1'b1;
        bus.md_i_lane_vld = lv;
        bus.md_i_instr    = {i1, i0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(32'h20010005, 32'h20020007, 2'b11, 2'b11, 1'b1, 1'b1, 9'h128, 9'h128,
                   opf(8, 5), opf(8, 7), fld(0, 1, 0, 5), fld(0, 2, 0, 7), 26'h0, 26'h0);
        vt[1] = mk(32'h03E00008, 32'hFC000000, 2'b11, 2'b11, 1'b1, 1'b1, 9'h180, 9'h000,
                   opf(0, 8), opf(0, 0), fld(31, 0, 0, 8), fld(0, 0, 0, 0), 26'h0, 26'h0);
        vt[2] = mk(32'h8C430004, 32'hACC50008, 2'b11, 2'b11, 1'b1, 1'b1, 9'h12A, 9'h109,
                   opf(35, 4), opf(43, 8), fld(2, 3, 0, 4), fld(6, 5, 0, 8), 26'h0, 26'h0);
        vt[3] = mk(32'h10220010, 32'h0C000123, 2'b11, 2'b11, 1'b1, 1'b1, 9'h110, 9'h164,
                   opf(4, 16), opf(3, 35), fld(1, 2, 0, 16), fld(0, 0, 31, 'h123), 26'h0, 26'h123);
        vt[4] = mk(32'h01093820, 32'h34A400FF, 2'b11, 2'b11, 1'b1, 1'b1, 9'h124, 9'h128,
                   opf(0, 32), opf(13, 63), fld(8, 9, 7, 'h3820), fld(5, 4, 0, 'hFF), 26'h0, 26'h0);
        vt[5] = mk(32'h20010005, 32'h00211020, 2'b01, 2'b01, 1'b1, 1'b0, 9'h128, 9'h000,
                   opf(8, 5), 12'h0, fld(0, 1, 0, 5), 31'h0, 26'h0, 26'h0);
        vt[6] = mk(32'h20010005, 32'h20020007, 2'b00, 2'b00, 1'b0, 1'b0, 9'h000, 9'h000,
                   12'h0, 12'h0, 31'h0, 31'h0, 26'h0, 26'h0);

        rst                = 1'b1;
        bus.md_i_valid     = 1'b0;
        bus.md_i_lane_vld  = '0;
        bus.md_i_instr     = '0;
        bus.md_i_flush     = 1'b0;
        bus.md_i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("reset valid", 64'(bus.md_o_valid), 64'h0);
        chk("reset ctrl", 64'(bus.md_o_ctrl), 64'h0);
        chk("reset ready", 64'(bus.md_o_ready), 64'h1);
        step();

        // Decode table, one bundle at a time with the issue side always ready.
        for (int i = 0; i < 7; i++) begin
            offer(vt[i].i0, vt[i].i1, vt[i].lv);
            #1;
            chk($sformatf("v%0d ready", i), 64'(bus.md_o_ready), 64'h1);
            step();
            bus.md_i_valid = 1'b0;
            chk($sformatf("v%0d valid", i), 64'(bus.md_o_valid), 64'(vt[i].evld));
            if (vt[i].chk0) begin
                chk($sformatf("v%0d ctrl0", i), 64'(bus.md_o_ctrl[8:0]), 64'(vt[i].c0));
                chk($sformatf("v%0d opf0", i), 64'(act_of(0)), 64'(vt[i].of0));
                chk($sformatf("v%0d fld0", i), 64'(act_f(0)), 64'(vt[i].f0));
                chk($sformatf("v%0d jal0", i), 64'(bus.md_o_jal_addr[25:0]), 64'(vt[i].j0));
            end
            if (vt[i].chk1) begin
                chk($sformatf("v%0d ctrl1", i), 64'(bus.md_o_ctrl[17:9]), 64'(vt[i].c1));
                chk($sformatf("v%0d opf1", i), 64'(act_of(1)), 64'(vt[i].of1));
                chk($sformatf("v%0d fld1", i), 64'(act_f(1)), 64'(vt[i].f1));
                chk($sformatf("v%0d jal1", i), 64'(bus.md_o_jal_addr[51:26]), 64'(vt[i].j1));
            end
            step();
            chk($sformatf("v%0d drain", i), 64'(bus.md_o_valid), 64'h0);
        end

        // RAW hazard inside one bundle: lane1 reads $1 written by lane0.
        offer(32'h20010005, 32'h00211020, 2'b11);
        step();
        bus.md_i_valid = 1'b0;
        #1;
`ifdef MDS_SPLIT_EN
        chk("split c1 valid", 64'(bus.md_o_valid), 64'h1);
        chk("split c1 ready", 64'(bus.md_o_ready), 64'h0);
        chk("split c1 rt0", 64'(bus.md_o_rt[4:0]), 64'd1);
        step();
        chk("split c2 valid", 64'(bus.md_o_valid), 64'h2);
        chk("split c2 rd1", 64'(bus.md_o_rd[9:5]), 64'd2);
        chk("split c2 ctrl1", 64'(bus.md_o_ctrl[17:9]), 64'h124);
`else
        chk("nosplit valid", 64'(bus.md_o_valid), 64'h3);
        chk("nosplit ready", 64'(bus.md_o_ready), 64'h1);
        chk("nosplit rd1", 64'(bus.md_o_rd[9:5]), 64'd2);
`endif
        step();
        chk("split drain", 64'(bus.md_o_valid), 64'h0);

        // Back-pressure: 3 stalled cycles, then the waiting bundle is taken.
        offer(32'h20010005, 32'h20020007, 2'b11);
        step();
        bus.md_i_out_ready = 1'b0;
        offer(32'h8C430004, 32'hACC50008, 2'b11);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d ready", c), 64'(bus.md_o_ready), 64'h0);
            chk($sformatf("stall%0d valid", c), 64'(bus.md_o_valid), 64'h3);
            chk($sformatf("stall%0d imm0", c), 64'(bus.md_o_imm[15:0]), 64'h5);
            chk($sformatf("stall%0d ctrl0", c), 64'(bus.md_o_ctrl[8:0]), 64'h128);
            step();
        end
        chk("stall end imm1", 64'(bus.md_o_imm[31:16]), 64'h7);
        bus.md_i_out_ready = 1'b1;
        #1;
        chk("release ready", 64'(bus.md_o_ready), 64'h1);
        step();
        bus.md_i_valid = 1'b0;
        chk("release valid", 64'(bus.md_o_valid), 64'h3);
        chk("release ctrl0", 64'(bus.md_o_ctrl[8:0]), 64'h12A);
        chk("release ctrl1", 64'(bus.md_o_ctrl[17:9]), 64'h109);
        step();
        chk("release drain", 64'(bus.md_o_valid), 64'h0);

        // Flush while output is busy and a new bundle is offered: flush wins.
        offer(32'h20010005, 32'h00211020, 2'b11);
        step();
        offer(32'h20010005, 32'h20020007, 2'b11);
        bus.md_i_flush = 1'b1;
        #1;
`ifdef MDS_SPLIT_EN
        chk("flush pre valid", 64'(bus.md_o_valid), 64'h1);
`else
        chk("flush pre valid", 64'(bus.md_o_valid), 64'h3);
`endif
        step();
        bus.md_i_flush = 1'b0;
        bus.md_i_valid = 1'b0;
        #1;
        chk("flush valid", 64'(bus.md_o_valid), 64'h0);
        chk("flush ready", 64'(bus.md_o_ready), 64'h1);
        step();
        chk("flush after valid", 64'(bus.md_o_valid), 64'h0);

        // Asynchronous reset in the middle of a split bundle.
        offer(32'h20010005, 32'h00211020, 2'b11);
        step();
        bus.md_i_valid     = 1'b0;
        bus.md_i_out_ready = 1'b0;
`ifdef MDS_SPLIT_EN
        chk("rst pre valid", 64'(bus.md_o_valid), 64'h1);
`else
        chk("rst pre valid", 64'(bus.md_o_valid), 64'h3);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("rst async valid", 64'(bus.md_o_valid), 64'h0);
        chk("rst async ctrl", 64'(bus.md_o_ctrl), 64'h0);
        chk("rst async fld0", 64'(act_f(0)), 64'h0);
        chk("rst async fld1", 64'(act_f(1)), 64'h0);
        chk("rst async opf", 64'({act_of(1), act_of(0)}), 64'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst release ready", 64'(bus.md_o_ready), 64'h1);
        bus.md_i_out_ready = 1'b1;
        step();
        chk("rst after valid", 64'(bus.md_o_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
